// File: rtl/bus_arbiter_pkg.sv
// Shared core bus types: Avalon-MM request/response bundles and the
// master-ID encoding used by the ibus/dbus arbiter.
`timescale 1ns/1ps
package bus_arbiter_pkg;

   typedef struct packed {
      logic [31:0] address;
      logic        read;
      logic        write;
      logic [31:0] writedata;
      logic [3:0]  byteenable;
   } avalon_req_t;

   typedef struct packed {
      logic        waitrequest;
      logic [31:0] readdata;
      logic        readdatavalid;
   } avalon_resp_t;

   typedef enum logic {
      IBUS = 1'b0,
      DBUS = 1'b1
   } master_id_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit master IDs for reads awaiting readdatavalid.
// Ports: clk, rst (sync, active high), push/push_id, pop, head, full, empty.
`timescale 1ns/1ps
module arb_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_id,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] ids;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = ids[rd_ptr];

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ids[wr_ptr] <= push_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter joining core ibus (master 0) and dbus (master 1)
// onto one Avalon-MM memory port; read responses are routed back in order.
// Ports: clk, rst (sync, active high); ibus/dbus req in, resp out;
// mem req out, resp in; arb_resp_error pulses on an orphan readdatavalid.
`timescale 1ns/1ps
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  avalon_req_t  ibus_avalon_req,
   output avalon_resp_t ibus_avalon_resp,
   input  avalon_req_t  dbus_avalon_req,
   output avalon_resp_t dbus_avalon_resp,
   output avalon_req_t  mem_avalon_req,
   input  avalon_resp_t mem_avalon_resp,
   output logic         arb_resp_error
);

   master_id_t last_grant;
   master_id_t gnt;
   master_id_t head_id;
   logic       gnt_valid;
   logic       ibus_ok;
   logic       dbus_ok;
   logic       accept;
   logic       push;
   logic       pop;
   logic       orphan;
   logic       id_full;
   logic       id_empty;
   logic       id_head;

   // A read cannot be issued while every ID slot is taken, so such a
   // master is dropped from arbitration; a write from the other one
   // can then still go through.
   assign ibus_ok = ibus_avalon_req.write |
                    (ibus_avalon_req.read & ~id_full);
   assign dbus_ok = dbus_avalon_req.write |
                    (dbus_avalon_req.read & ~id_full);

   always_comb begin
      gnt_valid = 1'b0;
      gnt       = IBUS;
      if (!rst) begin
         unique case (1'b1)
            (ibus_ok && dbus_ok): begin
               gnt_valid = 1'b1;
               gnt       = (last_grant == IBUS) ? DBUS : IBUS;
            end
            (ibus_ok && !dbus_ok): begin
               gnt_valid = 1'b1;
               gnt       = IBUS;
            end
            (!ibus_ok && dbus_ok): begin
               gnt_valid = 1'b1;
               gnt       = DBUS;
            end
            default: begin
               gnt_valid = 1'b0;
               gnt       = IBUS;
            end
         endcase
      end
   end

   always_comb begin
      mem_avalon_req = '0;
      if (gnt_valid) begin
         mem_avalon_req = (gnt == DBUS) ? dbus_avalon_req
                                        : ibus_avalon_req;
      end
   end

   assign accept = gnt_valid &
                   (mem_avalon_req.read | mem_avalon_req.write) &
                   ~mem_avalon_resp.waitrequest;
   assign push   = accept & mem_avalon_req.read;
   assign pop    = ~rst & mem_avalon_resp.readdatavalid & ~id_empty;
   assign orphan = ~rst & mem_avalon_resp.readdatavalid & id_empty;

   assign head_id = master_id_t'(id_head);

   always_comb begin
      ibus_avalon_resp             = '0;
      dbus_avalon_resp             = '0;
      ibus_avalon_resp.readdata    = mem_avalon_resp.readdata;
      dbus_avalon_resp.readdata    = mem_avalon_resp.readdata;
      ibus_avalon_resp.waitrequest = 1'b1;
      dbus_avalon_resp.waitrequest = 1'b1;
      if (gnt_valid && gnt == IBUS) begin
         ibus_avalon_resp.waitrequest = mem_avalon_resp.waitrequest;
      end
      if (gnt_valid && gnt == DBUS) begin
         dbus_avalon_resp.waitrequest = mem_avalon_resp.waitrequest;
      end
      ibus_avalon_resp.readdatavalid = pop & (head_id == IBUS);
      dbus_avalon_resp.readdatavalid = pop & (head_id == DBUS);
   end

   // Pointer moves only on acceptance so a stalled grant stays put.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant     <= IBUS;
         arb_resp_error <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= gnt;
         end
         arb_resp_error <= orphan;
      end
   end

   arb_id_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .push_id (logic'(gnt)),
      .pop     (pop),
      .head    (id_head),
      .full    (id_full),
      .empty   (id_empty)
   );

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int OUT = 4;

   logic         clk = 1'b0;
   logic         rst;
   avalon_req_t  ireq;
   avalon_req_t  dreq;
   avalon_req_t  mreq;
   avalon_resp_t iresp;
   avalon_resp_t dresp;
   avalon_resp_t mresp;
   logic         err;

   int checks = 0;
   int errors = 0;

   int q[$];
   int last_w = 0;
   bit err_exp = 1'b0;
   int win;
   bit exp_rd;
   bit exp_wr;
   bit pop_e;
   bit orphan_e;

   always #5 clk = ~clk;

   bus_arbiter #(.OUTSTANDING(OUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .ibus_avalon_req  (ireq),
      .ibus_avalon_resp (iresp),
      .dbus_avalon_req  (dreq),
      .dbus_avalon_resp (dresp),
      .mem_avalon_req   (mreq),
      .mem_avalon_resp  (mresp),
      .arb_resp_error   (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic avalon_req_t mk(bit rd, bit wr,
                                      logic [31:0] a, logic [31:0] d);
      avalon_req_t r;
      r            = '0;
      r.read       = rd;
      r.write      = wr;
      r.address    = a;
      r.writedata  = d;
      r.byteenable = 4'hF;
      return r;
   endfunction

   task automatic idle();
      ireq  = '0;
      dreq  = '0;
      mresp = '0;
   endtask

   // Model: FIFO of owner IDs plus the last winner; checks comb outputs.
   task automatic eval(input string tag);
      bit full;
      bit i_ok;
      bit d_ok;
      int head;
      avalon_req_t sel;
      #1;
      full = (q.size() == OUT);
      i_ok = ireq.write || (ireq.read && !full);
      d_ok = dreq.write || (dreq.read && !full);
      win  = -1;
      if (!rst) begin
         if (i_ok && d_ok) win = 1 - last_w;
         else if (i_ok)    win = 0;
         else if (d_ok)    win = 1;
      end
      sel    = (win == 1) ? dreq : ireq;
      exp_rd = (win >= 0) && sel.read;
      exp_wr = (win >= 0) && sel.write;
      chk({tag, "/mem_rd"}, mreq.read, exp_rd);
      chk({tag, "/mem_wr"}, mreq.write, exp_wr);
      if (win >= 0) begin
         chk({tag, "/mem_addr"}, mreq.address, sel.address);
         chk({tag, "/mem_wdata"}, mreq.writedata, sel.writedata);
      end
      chk({tag, "/i_wait"}, iresp.waitrequest,
          (win == 0) ? mresp.waitrequest : 1'b1);
      chk({tag, "/d_wait"}, dresp.waitrequest,
          (win == 1) ? mresp.waitrequest : 1'b1);
      pop_e    = !rst && mresp.readdatavalid && q.size() > 0;
      orphan_e = !rst && mresp.readdatavalid && q.size() == 0;
      head     = pop_e ? q[0] : -1;
      chk({tag, "/i_rdv"}, iresp.readdatavalid, pop_e && head == 0);
      chk({tag, "/d_rdv"}, dresp.readdatavalid, pop_e && head == 1);
      chk({tag, "/i_rdata"}, iresp.readdata, mresp.readdata);
      chk({tag, "/d_rdata"}, dresp.readdata, mresp.readdata);
   endtask

   task automatic tick(input string tag);
      bit acc;
      @(posedge clk);
      if (rst) begin
         q.delete();
         last_w  = 0;
         err_exp = 1'b0;
      end else begin
         acc = (win >= 0) && (exp_rd || exp_wr) && !mresp.waitrequest;
         if (pop_e) void'(q.pop_front());
         if (acc) begin
            last_w = win;
            if (exp_rd) q.push_back(win);
         end
         err_exp = orphan_e;
      end
      #1;
      chk({tag, "/err"}, err, err_exp);
      @(negedge clk);
   endtask

   task automatic cyc(input string tag);
      eval(tag);
      tick(tag);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      ireq = mk(1, 0, 32'h0000_1000, 0);
      @(negedge clk);
      eval("rst");
      chk("rst_mem_rd", mreq.read, 1'b0);
      tick("rst");
      chk("rst_err", err, 1'b0);
      rst = 1'b0;
      idle();
      cyc("idle");

      // Contention right after reset: dbus first, then ibus.
      ireq = mk(1, 0, 32'h0000_1000, 0);
      dreq = mk(1, 0, 32'h0000_2000, 0);
      eval("cont0");
      chk("cont0_addr", mreq.address, 32'h0000_2000);
      chk("cont0_dwait", dresp.waitrequest, 1'b0);
      tick("cont0");
      dreq = '0;
      eval("cont1");
      chk("cont1_addr", mreq.address, 32'h0000_1000);
      tick("cont1");
      idle();
      mresp.readdatavalid = 1'b1;
      mresp.readdata      = 32'h1111_1111;
      eval("cont_r0");
      chk("cont_r0_d", dresp.readdatavalid, 1'b1);
      tick("cont_r0");
      mresp.readdata = 32'h2222_2222;
      eval("cont_r1");
      chk("cont_r1_i", iresp.readdatavalid, 1'b1);
      tick("cont_r1");

      // Stall hold: make dbus the last winner, then ibus wins and stalls.
      idle();
      dreq = mk(0, 1, 32'h0000_2004, 32'hCAFE_0001);
      cyc("wr_d");
      ireq = mk(1, 0, 32'h0000_1010, 0);
      dreq = mk(1, 0, 32'h0000_2010, 0);
      for (int i = 0; i < 4; i++) begin
         mresp.waitrequest = (i < 3);
         eval("stall");
         chk("stall_addr", mreq.address, 32'h0000_1010);
         chk("stall_dwait", dresp.waitrequest, 1'b1);
         tick("stall");
      end
      eval("stall_d");
      chk("stall_d_addr", mreq.address, 32'h0000_2010);
      chk("stall_d_acc", dresp.waitrequest, 1'b0);
      tick("stall_d");

      // Two in flight (ibus, dbus): push and pop together.
      idle();
      ireq = mk(1, 0, 32'h0000_1020, 0);
      mresp.readdatavalid = 1'b1;
      mresp.readdata      = 32'h3333_3333;
      eval("pp");
      chk("pp_i_rdv", iresp.readdatavalid, 1'b1);
      tick("pp");
      ireq = '0;
      eval("pp_r0");
      chk("pp_r0_d", dresp.readdatavalid, 1'b1);
      tick("pp_r0");
      eval("pp_r1");
      chk("pp_r1_i", iresp.readdatavalid, 1'b1);
      tick("pp_r1");
      eval("pp_r2");
      chk("pp_r2_none", iresp.readdatavalid | dresp.readdatavalid, 1'b0);
      tick("pp_r2");

      // Full ID FIFO: fifth ibus read blocked, dbus write passes.
      idle();
      ireq = mk(1, 0, 32'h0000_1030, 0);
      for (int i = 0; i < OUT; i++) cyc("fill");
      dreq = mk(0, 1, 32'h0000_2030, 32'hCAFE_0002);
      eval("full");
      chk("full_rd", mreq.read, 1'b0);
      chk("full_wr", mreq.write, 1'b1);
      chk("full_iwait", iresp.waitrequest, 1'b1);
      chk("full_dwait", dresp.waitrequest, 1'b0);
      tick("full");
      idle();
      mresp.readdatavalid = 1'b1;
      for (int i = 0; i < OUT; i++) begin
         mresp.readdata = 32'h4000_0000 + i;
         eval("drain");
         chk("drain_i", iresp.readdatavalid, 1'b1);
         tick("drain");
      end

      // Orphan response.
      mresp.readdata = 32'hDEAD_BEEF;
      eval("orph");
      chk("orph_rdv", iresp.readdatavalid | dresp.readdatavalid, 1'b0);
      tick("orph");
      chk("orph_err", err, 1'b1);
      idle();
      cyc("orph_end");
      chk("orph_err_clr", err, 1'b0);

      // Reset with three reads in flight.
      ireq = mk(1, 0, 32'h0000_1040, 0);
      for (int i = 0; i < 3; i++) cyc("mid");
      idle();
      rst = 1'b1;
      cyc("mid_rst");
      rst = 1'b0;
      mresp.readdatavalid = 1'b1;
      mresp.readdata      = 32'h5555_5555;
      eval("mid_orph");
      chk("mid_rdv", iresp.readdatavalid | dresp.readdatavalid, 1'b0);
      tick("mid_orph");
      chk("mid_err", err, 1'b1);
      idle();
      cyc("mid_end");

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         int ki;
         int kd;
         ki = $urandom_range(0, 3);
         kd = $urandom_range(0, 3);
         ireq = mk(ki == 1, ki == 2, $urandom, $urandom);
         dreq = mk(kd == 1, kd == 2, $urandom, $urandom);
         mresp.waitrequest   = ($urandom_range(0, 2) == 0);
         mresp.readdatavalid = ($urandom_range(0, 9) < 4);
         mresp.readdata      = $urandom;
         rst = ($urandom_range(0, 199) == 0);
         cyc("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 4, meaning the maximum number of in-flight reads tracked (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ibus_avalon_req, input, avalon_req_t, the core instruction bus request (master 0).
REQ-005 SHALL have port ibus_avalon_resp, output, avalon_resp_t, the response to master 0.
REQ-006 SHALL have port dbus_avalon_req, input, avalon_req_t, the core data bus request (master 1).
REQ-007 SHALL have port dbus_avalon_resp, output, avalon_resp_t, the response to master 1.
REQ-008 SHALL have port mem_avalon_req, output, avalon_req_t, the shared memory-side request.
REQ-009 SHALL have port mem_avalon_resp, input, avalon_resp_t, the memory-side response: waitrequest, readdata, readdatavalid; reads return in order.
REQ-010 SHALL have port arb_resp_error, output, 1, a one-cycle pulse on an orphan readdatavalid.

Function
REQ-011 SHALL treat a master as requesting when its read or write is high; read and write together from one master are illegal.
REQ-012 SHALL grant combinationally in the same cycle: a single requester wins; with both requesting, the master not granted on the last accepted transfer wins (round-robin).
REQ-013 SHALL drive mem_avalon_req from the granted master, and all-zero read/write when there is no grant.
REQ-014 SHALL return mem waitrequest to the granted master and waitrequest=1 to any non-granted requesting master.
REQ-015 SHALL count a transfer as accepted when mem read/write is high and mem waitrequest=0; the round-robin pointer updates only on acceptance, so the grant holds stable while waitrequest stalls.
REQ-016 SHALL push the granted master ID into an OUTSTANDING-deep ID FIFO on each accepted read; writes are not tracked.
REQ-017 SHALL, while the ID FIFO is full, suppress reads toward memory (read=0) and force waitrequest=1 to a read-requesting master, even if a pop occurs the same cycle; writes still proceed.
REQ-018 SHALL route mem readdatavalid/readdata to the master at the FIFO head and pop in the same cycle; the other master sees readdatavalid=0.
REQ-019 SHALL allow a push and a pop in the same cycle when the FIFO is not full, with the count unchanged.
REQ-020 SHALL, on readdatavalid with an empty FIFO, route data to neither master, pulse arb_resp_error for one cycle, and leave state unchanged.
REQ-021 SHALL keep readdata to masters equal to mem readdata; only readdatavalid is gated.
REQ-022 SHALL add zero cycles of latency on the request path and on the response path.

Reset
REQ-023 SHALL, on rst, empty the ID FIFO, set the last-grant pointer to ibus (so dbus wins the first contention), and clear arb_resp_error.
REQ-024 SHALL, on rst asserted mid-transfer, discard all outstanding IDs; responses arriving afterwards are orphans per REQ-020.
REQ-025 SHALL force mem_avalon_req read and write to 0 while rst is high.

Structure
REQ-026 SHALL take avalon_req_t and avalon_resp_t from the shared core package; the master-ID encoding (IBUS=0, DBUS=1) SHALL also be placed in that package.
REQ-027 SHALL implement the ID FIFO as one sub-module, arb_id_fifo (1-bit data, depth OUTSTANDING, full/empty flags, synchronous reset).
REQ-028 SHALL be instantiated between veriRISCV_core ibus/dbus and a single-port memory.

Verification
REQ-029 SHALL cover contention: both masters read at cycle 0 after reset with waitrequest=0 -> dbus granted cycle 0, ibus cycle 1; responses route dbus then ibus.
REQ-030 SHALL cover stall hold: ibus read with mem waitrequest=1 for 3 cycles while dbus requests -> grant stays ibus for all 4 cycles; dbus accepted on cycle 4.
REQ-031 SHALL cover full FIFO: 4 ibus reads accepted with no readdatavalid -> 5th read sees waitrequest=1 and mem read=0; a dbus write in the same cycle is still accepted.
REQ-032 SHALL cover simultaneous push/pop: count at 2, accepted read plus readdatavalid in the same cycle -> count stays 2 and data goes to the head ID.
REQ-033 SHALL cover an orphan response: readdatavalid with data 0xDEADBEEF and an empty FIFO -> arb_resp_error=1 for one cycle and no master readdatavalid.
REQ-034 SHALL cover reset mid-flight: 3 reads outstanding, rst pulsed, then 1 readdatavalid -> error pulse and the FIFO remains empty.
